// File: rtl/bmu_count_engine.sv
// Iterative clz/ctz/cpop engine: examines CHUNK operand bits per cycle and
// accumulates the count, with valid/ready request and result handshakes.
module bmu_count_engine #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_error,
  output logic [1:0]      dbg_state
);

  localparam int NCH = XLEN / CHUNK;
  localparam int AW  = $clog2(XLEN) + 1;
  localparam int CW  = $clog2(CHUNK) + 1;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_CLZ  = 2'b00;
  localparam logic [1:0] OP_CTZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  logic [1:0]      r_state;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [AW-1:0]   r_acc;
  logic [IW-1:0]   r_idx;
  logic            r_err;

  logic [IW-1:0]    w_sel;
  logic [CHUNK-1:0] w_slice;
  logic [CW-1:0]    w_lz;
  logic [CW-1:0]    w_tz;
  logic [CW-1:0]    w_pop;
  logic [CW-1:0]    w_add;
  logic             w_nz;
  logic             w_last;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and held outputs stay stable until accepted.
  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = XLEN'(r_acc);
  assign out_error  = r_err;
  assign dbg_state  = r_state;

  always_comb begin
    w_sel   = (r_op == OP_CLZ) ? (LAST_IDX - r_idx) : r_idx;
    w_slice = CHUNK'(r_a >> (int'(w_sel) * CHUNK));
    w_nz    = |w_slice;
    w_last  = (r_idx == LAST_IDX);
    // Later loop iterations override earlier ones, so the MSB-most one sets
    // the leading count and the LSB-most one sets the trailing count.
    w_lz  = CW'(CHUNK);
    w_tz  = CW'(CHUNK);
    w_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (w_slice[i]) w_lz = CW'(CHUNK - 1 - i);
      w_pop = w_pop + CW'(w_slice[i]);
    end
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (w_slice[i]) w_tz = CW'(i);
    end
    case (r_op)
      OP_CLZ:  w_add = w_lz;
      OP_CTZ:  w_add = w_tz;
      default: w_add = w_pop;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_CLZ;
      r_a     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= in_op;
            r_a   <= in_a;
            r_acc <= '0;
            r_idx <= '0;
            if (in_op == OP_RSVD) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_acc <= r_acc + AW'(w_add);
          r_idx <= r_idx + IW'(1);
          // clz/ctz stop at the first slice holding a one; cpop always sweeps.
          if (((r_op != OP_CPOP) && w_nz) || w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmu_count_engine.sv
// Directed bench for bmu_count_engine: a driver issues requests and queues the
// expected {error,result} and latency; a monitor checks outputs as they appear.
module tb_bmu_count_engine;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_error;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  logic [XLEN:0] exp_q[$];
  int            lat_q[$];

  logic          prev_v;
  logic          prev_hold;
  logic [XLEN:0] prev_res;
  logic [XLEN:0] mon_e;
  int            mon_l;

  bmu_count_engine #(.XLEN(XLEN), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_error(out_error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver
  task automatic send(input logic [1:0] op, input logic [XLEN-1:0] a, input logic push,
                      input logic [XLEN-1:0] er, input logic ee, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
    if (push) begin
      exp_q.push_back({ee, er});
      lat_q.push_back(lat);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !in_ready) check("drain_timeout", 64'd0, 64'd1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_v    = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (lat_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
        else begin
          mon_l = lat_q.pop_front();
          check("latency", 64'(cyc - acc_cyc), 64'(mon_l));
        end
      end
      if (out_valid && prev_hold) check("hold_stable", 64'({out_error, out_result}), 64'(prev_res));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("result", 64'({out_error, out_result}), 64'(mon_e));
        end
      end
      prev_v    = out_valid;
      prev_hold = out_valid && !out_ready;
      prev_res  = {out_error, out_result};
    end
  end

  logic [1:0]      v_op  [10];
  logic [XLEN-1:0] v_a   [10];
  logic [XLEN-1:0] v_exp [10];
  int              v_lat [10];

  initial begin
    v_op[0] = 2'b00; v_a[0] = 32'h0001_0000; v_exp[0] = 15; v_lat[0] = 2;
    v_op[1] = 2'b01; v_a[1] = 32'h8000_0000; v_exp[1] = 31; v_lat[1] = 4;
    v_op[2] = 2'b01; v_a[2] = 32'h0000_0000; v_exp[2] = 32; v_lat[2] = 4;
    v_op[3] = 2'b00; v_a[3] = 32'h0000_0000; v_exp[3] = 32; v_lat[3] = 4;
    v_op[4] = 2'b00; v_a[4] = 32'h8000_0000; v_exp[4] = 0;  v_lat[4] = 1;
    v_op[5] = 2'b10; v_a[5] = 32'hFFFF_FFFF; v_exp[5] = 32; v_lat[5] = 4;
    v_op[6] = 2'b10; v_a[6] = 32'h0000_0000; v_exp[6] = 0;  v_lat[6] = 4;
    v_op[7] = 2'b10; v_a[7] = 32'hA5A5_0F0F; v_exp[7] = 16; v_lat[7] = 4;
    v_op[8] = 2'b01; v_a[8] = 32'h0000_0100; v_exp[8] = 8;  v_lat[8] = 2;
    v_op[9] = 2'b00; v_a[9] = 32'h00F0_0000; v_exp[9] = 8;  v_lat[9] = 2;

    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_error", 64'(out_error), 64'd0);
    check("reset_out_result", 64'(out_result), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      send(v_op[i], v_a[i], 1'b1, v_exp[i], 1'b0, v_lat[i]);
      drain();
    end

    // backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2'b00, 32'h0000_0001, 1'b1, 31, 1'b0, 4);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_valid_held", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);

    // flush in the second RUN cycle of a cpop
    send(2'b10, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_run_valid", 64'(out_valid), 64'd0);
    check("flush_run_state", 64'(dbg_state), 64'd0);
    check("flush_run_in_ready", 64'(in_ready), 64'd1);
    repeat (8) @(negedge clk);
    check("flush_run_no_valid", 64'(out_valid), 64'd0);

    // flush coincident with a request in IDLE
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_a = 32'h0000_0001;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_accept_state", 64'(dbg_state), 64'd0);
    check("flush_accept_in_ready", 64'(in_ready), 64'd1);
    repeat (6) @(negedge clk);
    check("flush_accept_no_valid", 64'(out_valid), 64'd0);

    // reset mid-RUN with a partially accumulated count
    send(2'b10, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_run_out_valid", 64'(out_valid), 64'd0);
    check("rst_run_out_error", 64'(out_error), 64'd0);
    check("rst_run_out_result", 64'(out_result), 64'd0);
    check("rst_run_in_ready", 64'(in_ready), 64'd1);
    check("rst_run_state", 64'(dbg_state), 64'd0);

    // reserved op then a normal clz
    send(2'b11, 32'h1234_5678, 1'b1, 0, 1'b1, 0);
    drain();
    send(2'b00, 32'h0000_00FF, 1'b1, 24, 1'b0, 4);
    drain();

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
